// File: rtl/ndm_reset_seq.sv
// ndm_reset_seq: reset sequencer behind the debug module.
//   Takes the DM's ndmreset and a watchdog request, and drives stretched,
//   ordered resets: peripherals and core assert together, and the peripherals
//   are always released before the core. It reports the hart's reset status
//   back to the DM and records the cause of the last reset.
// Ports:
//   clk              in   system clock (DebugModule domain)
//   rst              in   asynchronous active-high reset (power-on)
//   ndmreset         in   non-debug-module reset request (level)
//   wdt_rst_req      in   watchdog reset request (level)
//   rst_cause_clr    in   strobe; clears rst_cause while idle
//   core_rst         out  active-high reset to the hart
//   periph_rst       out  active-high reset to peripherals/bus
//   core_is_in_reset out  high whenever the sequencer is not idle
//   rst_cause        out  00 none, 01 POR, 10 ndmreset, 11 watchdog
module ndm_reset_seq #(
    parameter int unsigned ASSERT_CYCLES  = 16,
    parameter int unsigned RELEASE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ndmreset,
    input  logic       wdt_rst_req,
    input  logic       rst_cause_clr,
    output logic       core_rst,
    output logic       periph_rst,
    output logic       core_is_in_reset,
    output logic [1:0] rst_cause
);

    localparam int unsigned MAX_CYCLES = (ASSERT_CYCLES > RELEASE_CYCLES) ? ASSERT_CYCLES : RELEASE_CYCLES;
    localparam int unsigned CW = $clog2(MAX_CYCLES) + 1;
    localparam logic [CW-1:0] ASSERT_LAST  = CW'(ASSERT_CYCLES - 1);
    localparam logic [CW-1:0] RELEASE_LAST = CW'(RELEASE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX      = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_HOLD,
        S_RELEASE
    } state_e;

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]  cause_q, cause_d;
    logic        core_rst_q, core_rst_d;
    logic        periph_rst_q, periph_rst_d;
    logic        req;
    logic [1:0]  req_cause;

    assign req       = ndmreset | wdt_rst_req;
    assign req_cause = wdt_rst_req ? 2'b11 : 2'b10;
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_ASSERT;
                    cnt_d   = '0;
                    cause_d = req_cause;
                end else if (rst_cause_clr) begin
                    cause_d = 2'b00;
                end
            end
            S_ASSERT: begin
                cnt_d   = cnt_inc;
                state_d = (cnt_q == ASSERT_LAST) ? S_HOLD : S_ASSERT;
            end
            S_HOLD: begin
                if (!req) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end
            end
            S_RELEASE: begin
                // A fresh request restarts the sequence even on the last release cycle.
                if (req) begin
                    state_d = S_ASSERT;
                    cnt_d   = '0;
                    cause_d = req_cause;
                end else begin
                    cnt_d   = cnt_inc;
                    state_d = (cnt_q == RELEASE_LAST) ? S_IDLE : S_RELEASE;
                end
            end
            default: begin
                state_d = S_ASSERT;
                cnt_d   = '0;
            end
        endcase
        // Outputs are registered from the next state so they cannot glitch.
        core_rst_d   = (state_d != S_IDLE);
        periph_rst_d = (state_d == S_ASSERT) || (state_d == S_HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_ASSERT;
            cnt_q        <= '0;
            cause_q      <= 2'b01;
            core_rst_q   <= 1'b1;
            periph_rst_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cause_q      <= cause_d;
            core_rst_q   <= core_rst_d;
            periph_rst_q <= periph_rst_d;
        end
    end

    assign core_rst         = core_rst_q;
    assign core_is_in_reset = core_rst_q;
    assign periph_rst       = periph_rst_q;
    assign rst_cause        = cause_q;

    periph_inside_core: assert property (@(posedge clk) disable iff (rst) periph_rst |-> core_rst);

endmodule

// File: tb/tb_ndm_reset_seq.sv
// tb_ndm_reset_seq: directed self-checking bench for ndm_reset_seq.
module tb_ndm_reset_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ndmreset = 1'b0;
    logic       wdt_rst_req = 1'b0;
    logic       rst_cause_clr = 1'b0;
    logic       core_rst;
    logic       periph_rst;
    logic       core_is_in_reset;
    logic [1:0] rst_cause;

    int n_tests = 0;
    int n_fail  = 0;
    int nc, np, bad, pk, ck;

    ndm_reset_seq #(
        .ASSERT_CYCLES (16),
        .RELEASE_CYCLES(8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ndmreset        (ndmreset),
        .wdt_rst_req     (wdt_rst_req),
        .rst_cause_clr   (rst_cause_clr),
        .core_rst        (core_rst),
        .periph_rst      (periph_rst),
        .core_is_in_reset(core_is_in_reset),
        .rst_cause       (rst_cause)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts samples with core_rst/periph_rst high until core_rst drops,
    // starting with the current sample; flags status/ordering violations.
    task automatic measure(output int c, output int p, output int b);
        c = 0;
        p = 0;
        b = 0;
        for (int i = 0; i < 200 && core_rst; i++) begin
            c++;
            if (periph_rst) p++;
            if (core_is_in_reset !== core_rst) b++;
            step();
        end
        if (core_rst) c = -1;
        if (core_is_in_reset !== core_rst) b++;
        if (periph_rst) b++;
    endtask

    // Edges after the current sample until periph_rst and core_rst fall.
    task automatic fall_edges(output int p, output int c);
        p = 0;
        c = 0;
        for (int k = 1; k <= 50; k++) begin
            step();
            if (!periph_rst && p == 0) p = k;
            if (!core_rst) begin
                c = k;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: power-on reset
        repeat (3) step();
        check("por_core", core_rst, 1);
        check("por_periph", periph_rst, 1);
        check("por_cir", core_is_in_reset, 1);
        check("por_cause", rst_cause, 2'b01);
        rst = 1'b0;
        measure(nc, np, bad);
        check("por_core_len", nc, 25);
        check("por_periph_len", np, 17);
        check("por_bad", bad, 0);
        check("por_cause_after", rst_cause, 2'b01);

        // 2: single-cycle ndmreset pulse
        ndmreset = 1'b1;
        step();
        ndmreset = 1'b0;
        check("pulse_core_now", core_rst, 1);
        measure(nc, np, bad);
        check("pulse_core_len", nc, 25);
        check("pulse_periph_len", np, 17);
        check("pulse_bad", bad, 0);
        check("pulse_cause", rst_cause, 2'b10);

        // 3: ndmreset held for 100 cycles
        ndmreset = 1'b1;
        repeat (100) step();
        check("held_core", core_rst, 1);
        check("held_periph", periph_rst, 1);
        ndmreset = 1'b0;
        fall_edges(pk, ck);
        check("held_periph_fall", pk, 1);
        check("held_core_fall", ck, 9);

        // 4: watchdog priority and cause clearing
        ndmreset = 1'b1;
        wdt_rst_req = 1'b1;
        step();
        ndmreset = 1'b0;
        wdt_rst_req = 1'b0;
        check("both_cause", rst_cause, 2'b11);
        rst_cause_clr = 1'b1;
        step();
        rst_cause_clr = 1'b0;
        check("clr_in_assert", rst_cause, 2'b11);
        measure(nc, np, bad);
        check("both_cause_idle", rst_cause, 2'b11);
        rst_cause_clr = 1'b1;
        step();
        rst_cause_clr = 1'b0;
        check("clr_in_idle", rst_cause, 2'b00);
        check("clr_core_idle", core_rst, 0);
        ndmreset = 1'b1;
        rst_cause_clr = 1'b1;
        step();
        ndmreset = 1'b0;
        rst_cause_clr = 1'b0;
        check("req_beats_clr", rst_cause, 2'b10);
        measure(nc, np, bad);
        check("req_clr_core_len", nc, 25);
        check("req_clr_periph_len", np, 17);

        // 5: watchdog at RELEASE cnt=5 restarts the sequence
        ndmreset = 1'b1;
        step();
        ndmreset = 1'b0;
        repeat (22) step();
        check("rel5_periph", periph_rst, 0);
        check("rel5_core", core_rst, 1);
        wdt_rst_req = 1'b1;
        step();
        wdt_rst_req = 1'b0;
        check("rel5_periph_back", periph_rst, 1);
        check("rel5_cause", rst_cause, 2'b11);
        measure(nc, np, bad);
        check("rel5_core_len", nc, 25);
        check("rel5_periph_len", np, 17);
        check("rel5_bad", bad, 0);

        // 5b: request on the last RELEASE cycle beats the exit to IDLE
        ndmreset = 1'b1;
        step();
        ndmreset = 1'b0;
        repeat (24) step();
        check("rel7_core", core_rst, 1);
        check("rel7_periph", periph_rst, 0);
        ndmreset = 1'b1;
        step();
        ndmreset = 1'b0;
        check("rel7_core_kept", core_rst, 1);
        check("rel7_periph_back", periph_rst, 1);
        measure(nc, np, bad);
        check("rel7_core_len", nc, 25);
        check("rel7_periph_len", np, 17);

        // 6: rst during HOLD with ndmreset high
        ndmreset = 1'b1;
        repeat (31) step();
        check("hold_cause", rst_cause, 2'b10);
        rst = 1'b1;
        #1;
        check("rst_core", core_rst, 1);
        check("rst_periph", periph_rst, 1);
        check("rst_cir", core_is_in_reset, 1);
        check("rst_cause", rst_cause, 2'b01);
        step();
        step();
        rst = 1'b0;
        repeat (40) step();
        check("rst_hold_core", core_rst, 1);
        check("rst_hold_periph", periph_rst, 1);
        check("rst_hold_cause", rst_cause, 2'b01);
        ndmreset = 1'b0;
        fall_edges(pk, ck);
        check("rst_hold_periph_fall", pk, 1);
        check("rst_hold_core_fall", ck, 9);

        // 6b: rst mid-RELEASE, then a plain POR-length sequence
        ndmreset = 1'b1;
        step();
        ndmreset = 1'b0;
        repeat (20) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_rel_periph", periph_rst, 1);
        measure(nc, np, bad);
        check("rst_rel_core_len", nc, 25);
        check("rst_rel_periph_len", np, 17);
        check("rst_rel_cause", rst_cause, 2'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
